pc_sequencer: RTL and testbench
===============================

Name: pc_sequencer

Overview:
Parametrised program-counter sequencer for the pipelined core. It holds the fetch PC and advances it by INST_BYTES each cycle. It applies branch, jalr and trap redirects and keeps a DEPTH-deep shift register of PC history for downstream stages. It drives a multi-cycle pipeline flush after any redirect, and detects misaligned branch targets, converting them into a trap with a captured EPC.

Parameters:
XLEN, 32, datapath/PC width in bits
DEPTH, 2, number of PC history stages (min 1)
INST_BYTES, 4, sequential increment; alignment granule (power of 2)
RESET_VECTOR, 0, PC value loaded on reset
FLUSH_CYCLES, 1, cycles pipe_flush stays high after a redirect (min 1)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
val1  in  XLEN  rs1 operand (jalr base)
imm  in  XLEN  sign-extended immediate
_type  in  4  instruction class; 4'b0111 = jalr, 4'b1001 = auipc
enable  in  1  branch unit valid
branch  in  1  branch/jump taken
stall  in  1  hold PC and history
trap  in  1  synchronous trap request
trap_vec  in  XLEN  trap handler address
pc  out  XLEN  current fetch PC
pc_hist  out  XLEN*DEPTH  history; slice k = PC k+1 advances ago (slice 0 = previous PC)
pc_out  out  XLEN  combinational: auipc -> pc_hist[0]+imm, else pc_hist[0]
pipe_flush  out  1  flush younger pipeline stages
misalign  out  1  one-cycle pulse on misaligned target
epc  out  XLEN  PC of the faulting branch, held until the next misalign

Behaviour:
- Reset (rst_n=0, async): pc=RESET_VECTOR; all pc_hist slices=RESET_VECTOR; pipe_flush=0; misalign=0; epc=0; flush counter=0.
- Per rising edge, priority high to low:
  1. trap=1: pc<=trap_vec. Honoured even when stall=1.
  2. stall=1: pc and pc_hist hold. Redirect request is ignored (not queued).
  3. enable&branch with aligned target: pc<=target.
  4. enable&branch with misaligned target (target mod INST_BYTES != 0): pc<=trap_vec; misalign<=1; epc<=pc_hist[0].
  5. Otherwise: pc<=pc+INST_BYTES.
- Target computation:
  - jalr: (val1+imm) with bit0 cleared, then the alignment check.
  - Other branches: pc_hist[0]+imm.
  - All arithmetic is modulo 2^XLEN, and wrap-around is silent.
- History: when no stall, or on a trap, pc_hist[0]<=pc and pc_hist[k]<=pc_hist[k-1]. While stalled without a trap, history holds.
- A redirect is any of cases 1, 3 or 4.
  - Flush counter loads FLUSH_CYCLES on a redirect; otherwise it decrements while nonzero, including during stall.
  - pipe_flush is registered: it is high in the cycle after the redirect and stays high while the counter is nonzero, i.e. exactly FLUSH_CYCLES cycles.
  - A redirect during an active flush reloads the counter, extending the flush.
- misalign is high for exactly one cycle after the faulting edge; otherwise 0.
- pc_out is purely combinational from pc_hist[0], imm and _type. No latency.
- Reset asserted mid-flush or mid-stall clears all state immediately. The first edge after rst_n rises produces pc=RESET_VECTOR+INST_BYTES.

Test Plan:
- Sequential run: reset, release, 4 edges, default params -> pc=0x10; pc_hist[0]=0x0C; pc_hist[1]=0x08; pipe_flush=0 throughout.
- Branch: at pc=0x10 (pc_hist[0]=0x0C), enable=branch=1, imm=0x20, _type=0 -> next pc=0x2C; pipe_flush=1 for exactly 1 cycle. With FLUSH_CYCLES=3 -> pipe_flush=1 for exactly 3 cycles.
- jalr: val1=0x101, imm=0x0F, _type=0111 -> computed 0x110 with bit0 cleared = 0x110, aligned -> pc=0x110.
- jalr misaligned: val1=0x102, imm=0 -> target 0x102, misaligned -> pc=trap_vec (0x800); misalign pulses for 1 cycle; epc=pc_hist[0] at the fault.
- Priority: stall=1 with enable=branch=1 -> pc and history unchanged, no flush. Then trap=1 with stall=1 -> pc=trap_vec and pipe_flush asserted.
- auipc and wrap: pc_hist[0]=0x40, imm=0x1000, _type=1001 -> pc_out=0x1040. With XLEN=16 and pc=0xFFFC, no branch -> next pc=0x0000.

Source files
------------

// File: rtl/pc_sequencer_if.sv
// Bus bundle between the pipelined core and the PC sequencer.
// The master side (core / testbench) supplies branch-unit and trap inputs;
// the slave side (the sequencer) returns the fetch PC, history and status.
interface pc_sequencer_if #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned DEPTH = 2
);
    // Inputs to the sequencer
    logic [XLEN-1:0]       val1;
    logic [XLEN-1:0]       imm;
    logic [3:0]            _type;
    logic                  enable;
    logic                  branch;
    logic                  stall;
    logic                  trap;
    logic [XLEN-1:0]       trap_vec;

    // Outputs from the sequencer
    logic [XLEN-1:0]       pc;
    logic [XLEN*DEPTH-1:0] pc_hist;
    logic [XLEN-1:0]       pc_out;
    logic                  pipe_flush;
    logic                  misalign;
    logic [XLEN-1:0]       epc;

    modport master (
        output val1, imm, _type, enable, branch, stall, trap, trap_vec,
        input  pc, pc_hist, pc_out, pipe_flush, misalign, epc
    );

    modport slave (
        input  val1, imm, _type, enable, branch, stall, trap, trap_vec,
        output pc, pc_hist, pc_out, pipe_flush, misalign, epc
    );
endinterface

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: advances the fetch PC, applies trap / branch /
// jalr redirects, keeps a shift register of previous PCs, stretches a
// pipeline flush after every redirect and turns misaligned branch targets
// into a trap with a captured EPC.
module pc_sequencer #(
    parameter int unsigned     XLEN         = 32,
    parameter int unsigned     DEPTH        = 2,
    parameter int unsigned     INST_BYTES   = 4,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0,
    parameter int unsigned     FLUSH_CYCLES = 1
) (
    input  logic           clk,
    input  logic           rst_n,
    pc_sequencer_if.slave  bus
);

    localparam logic [3:0]      TYPE_JALR  = 4'b0111;
    localparam logic [3:0]      TYPE_AUIPC = 4'b1001;
    localparam int unsigned     CNT_W      = $clog2(FLUSH_CYCLES + 1);
    localparam logic [XLEN-1:0] PC_STEP    = XLEN'(INST_BYTES);
    localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'(INST_BYTES - 1);
    localparam logic [CNT_W-1:0] FLUSH_LOAD = CNT_W'(FLUSH_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO   = CNT_W'(0);

    // What the next rising edge will do to the PC, in priority order
    typedef enum logic [2:0] {
        ACT_TRAP     = 3'd0,
        ACT_HOLD     = 3'd1,
        ACT_BRANCH   = 3'd2,
        ACT_MISALIGN = 3'd3,
        ACT_SEQ      = 3'd4
    } action_e;

    // Architectural state
    logic [XLEN-1:0]  pc_q;
    logic [XLEN-1:0]  pc_d;
    logic [XLEN-1:0]  hist_q [DEPTH];
    logic [CNT_W-1:0] flush_cnt_q;
    logic [CNT_W-1:0] flush_cnt_d;
    logic             flush_q;
    logic             flush_d;
    logic             misalign_q;
    logic [XLEN-1:0]  epc_q;

    // Combinational helpers
    logic [XLEN-1:0]       jalr_sum_s;
    logic [XLEN-1:0]       target_s;
    logic                  target_misaligned_s;
    action_e               action_s;
    logic                  shift_s;
    logic                  redirect_s;
    logic                  fault_s;
    logic [XLEN-1:0]       pc_out_s;
    logic [XLEN*DEPTH-1:0] hist_flat_s;

    // Branch target: jalr uses rs1+imm with bit 0 forced low, others are PC-relative to the previous PC
    always_comb begin
        jalr_sum_s = bus.val1 + bus.imm;
        if (bus._type == TYPE_JALR) begin
            target_s = {jalr_sum_s[XLEN-1:1], 1'b0};
        end else begin
            target_s = hist_q[0] + bus.imm;
        end
        target_misaligned_s = |(target_s & ALIGN_MASK);
    end

    // Priority decode of the next PC action: trap beats stall beats branch beats sequential
    always_comb begin
        if (bus.trap) begin
            action_s = ACT_TRAP;
        end else if (bus.stall) begin
            action_s = ACT_HOLD;
        end else if (bus.enable && bus.branch) begin
            if (target_misaligned_s) begin
                action_s = ACT_MISALIGN;
            end else begin
                action_s = ACT_BRANCH;
            end
        end else begin
            action_s = ACT_SEQ;
        end
    end

    // Next PC, history-shift enable, redirect and fault flags for the decoded action
    always_comb begin
        pc_d       = pc_q;
        shift_s    = 1'b0;
        redirect_s = 1'b0;
        fault_s    = 1'b0;
        case (action_s)
            ACT_TRAP: begin
                pc_d       = bus.trap_vec;
                shift_s    = 1'b1;
                redirect_s = 1'b1;
            end
            ACT_HOLD: begin
                pc_d    = pc_q;
                shift_s = 1'b0;
            end
            ACT_BRANCH: begin
                pc_d       = target_s;
                shift_s    = 1'b1;
                redirect_s = 1'b1;
            end
            ACT_MISALIGN: begin
                pc_d       = bus.trap_vec;
                shift_s    = 1'b1;
                redirect_s = 1'b1;
                fault_s    = 1'b1;
            end
            ACT_SEQ: begin
                pc_d    = pc_q + PC_STEP;
                shift_s = 1'b1;
            end
            default: begin
                pc_d       = pc_q;
                shift_s    = 1'b0;
                redirect_s = 1'b0;
                fault_s    = 1'b0;
            end
        endcase
    end

    // Flush counter: reload on every redirect (extending an active flush), else count down to zero
    always_comb begin
        flush_cnt_d = flush_cnt_q;
        if (redirect_s) begin
            flush_cnt_d = FLUSH_LOAD;
        end else if (flush_cnt_q != CNT_ZERO) begin
            flush_cnt_d = flush_cnt_q - CNT_ONE;
        end else begin
            flush_cnt_d = flush_cnt_q;
        end
        flush_d = (flush_cnt_d != CNT_ZERO);
    end

    // PC register and history shift register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q <= RESET_VECTOR;
            for (int k = 0; k < DEPTH; k++) begin
                hist_q[k] <= RESET_VECTOR;
            end
        end else begin
            pc_q <= pc_d;
            if (shift_s) begin
                hist_q[0] <= pc_q;
                for (int k = 1; k < DEPTH; k++) begin
                    hist_q[k] <= hist_q[k-1];
                end
            end
        end
    end

    // Flush counter and registered pipe_flush
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flush_cnt_q <= CNT_ZERO;
            flush_q     <= 1'b0;
        end else begin
            flush_cnt_q <= flush_cnt_d;
            flush_q     <= flush_d;
        end
    end

    // Misalign pulse and EPC capture (EPC holds until the next fault)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            misalign_q <= 1'b0;
            epc_q      <= '0;
        end else begin
            misalign_q <= fault_s;
            if (fault_s) begin
                epc_q <= hist_q[0];
            end
        end
    end

    // auipc result is relative to the PC of the instruction in the next stage
    always_comb begin
        if (bus._type == TYPE_AUIPC) begin
            pc_out_s = hist_q[0] + bus.imm;
        end else begin
            pc_out_s = hist_q[0];
        end
    end

    // Flatten the history array, slice 0 being the most recent previous PC
    always_comb begin
        hist_flat_s = '0;
        for (int k = 0; k < DEPTH; k++) begin
            hist_flat_s[k*XLEN +: XLEN] = hist_q[k];
        end
    end

    assign bus.pc         = pc_q;
    assign bus.pc_hist    = hist_flat_s;
    assign bus.pc_out     = pc_out_s;
    assign bus.pipe_flush = flush_q;
    assign bus.misalign   = misalign_q;
    assign bus.epc        = epc_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Testbench for pc_sequencer: two 32-bit instances (flush length 1 and 3)
// share the same directed stimulus and are compared every cycle against a
// behavioural model; a 16-bit instance checks PC wrap-around.
module tb_pc_sequencer;

    localparam logic [3:0] T_JALR  = 4'b0111;
    localparam logic [3:0] T_AUIPC = 4'b1001;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    // Shared stimulus for the 32-bit instances
    logic [31:0] val1     = 32'h0;
    logic [31:0] imm      = 32'h0;
    logic [3:0]  typ      = 4'h0;
    logic        enable   = 1'b0;
    logic        branch   = 1'b0;
    logic        stall    = 1'b0;
    logic        trap     = 1'b0;
    logic [31:0] trap_vec = 32'h800;

    pc_sequencer_if #(.XLEN(32), .DEPTH(2)) if_a ();
    pc_sequencer_if #(.XLEN(32), .DEPTH(2)) if_b ();
    pc_sequencer_if #(.XLEN(16), .DEPTH(2)) if_w ();

    assign if_a.val1 = val1;   assign if_b.val1 = val1;
    assign if_a.imm = imm;     assign if_b.imm = imm;
    assign if_a._type = typ;   assign if_b._type = typ;
    assign if_a.enable = enable; assign if_b.enable = enable;
    assign if_a.branch = branch; assign if_b.branch = branch;
    assign if_a.stall = stall; assign if_b.stall = stall;
    assign if_a.trap = trap;   assign if_b.trap = trap;
    assign if_a.trap_vec = trap_vec; assign if_b.trap_vec = trap_vec;

    assign if_w.val1 = 16'h0;
    assign if_w.imm = 16'h0;
    assign if_w._type = 4'h0;
    assign if_w.enable = 1'b0;
    assign if_w.branch = 1'b0;
    assign if_w.stall = 1'b0;
    assign if_w.trap = 1'b0;
    assign if_w.trap_vec = 16'h0;

    pc_sequencer #(.XLEN(32), .DEPTH(2), .INST_BYTES(4), .RESET_VECTOR(32'h0), .FLUSH_CYCLES(1))
        dut_a (.clk(clk), .rst_n(rst_n), .bus(if_a.slave));
    pc_sequencer #(.XLEN(32), .DEPTH(2), .INST_BYTES(4), .RESET_VECTOR(32'h0), .FLUSH_CYCLES(3))
        dut_b (.clk(clk), .rst_n(rst_n), .bus(if_b.slave));
    pc_sequencer #(.XLEN(16), .DEPTH(2), .INST_BYTES(4), .RESET_VECTOR(16'hFFF0), .FLUSH_CYCLES(1))
        dut_w (.clk(clk), .rst_n(rst_n), .bus(if_w.slave));

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Flush is modelled by the edge index of the last redirect: the flush
    // window covers the FC cycles that follow that edge.
    logic [31:0] m_pc;
    logic [31:0] m_h [2];
    logic [31:0] m_epc;
    logic        m_mis;
    int          edge_n;
    int          last_redir;

    task automatic m_reset();
        m_pc       = 32'h0;
        m_h[0]     = 32'h0;
        m_h[1]     = 32'h0;
        m_epc      = 32'h0;
        m_mis      = 1'b0;
        edge_n     = 0;
        last_redir = -1000;
    endtask

    task automatic m_step();
        logic [31:0] tgt;
        logic [31:0] nxt;
        bit          adv;
        bit          redir;
        bit          fault;
        edge_n++;
        adv   = 1'b1;
        redir = 1'b0;
        fault = 1'b0;
        if (typ == T_JALR) tgt = (val1 + imm) - ((val1 + imm) % 32'd2);
        else               tgt = m_h[0] + imm;
        if (trap) begin
            nxt = trap_vec; redir = 1'b1;
        end else if (stall) begin
            nxt = m_pc; adv = 1'b0;
        end else if (enable && branch) begin
            redir = 1'b1;
            if (tgt % 32'd4 != 32'd0) begin
                nxt = trap_vec; fault = 1'b1; m_epc = m_h[0];
            end else begin
                nxt = tgt;
            end
        end else begin
            nxt = m_pc + 32'd4;
        end
        if (adv) begin
            m_h[1] = m_h[0];
            m_h[0] = m_pc;
        end
        m_pc  = nxt;
        m_mis = fault;
        if (redir) last_redir = edge_n;
    endtask

    function automatic logic exp_flush(input int fc);
        return (edge_n - last_redir) < fc;
    endfunction

    // Model update on every edge (and asynchronously on reset)
    initial begin
        m_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) m_reset();
            else        m_step();
        end
    end

    // Compare process: every falling edge, all outputs of both 32-bit instances
    initial begin
        forever begin
            @(negedge clk);
            chk("pc_a",     if_a.pc,               m_pc);
            chk("hist0_a",  if_a.pc_hist[31:0],    m_h[0]);
            chk("hist1_a",  if_a.pc_hist[63:32],   m_h[1]);
            chk("pcout_a",  if_a.pc_out,           (typ == T_AUIPC) ? m_h[0] + imm : m_h[0]);
            chk("flush_a",  {31'h0, if_a.pipe_flush}, {31'h0, exp_flush(1)});
            chk("mis_a",    {31'h0, if_a.misalign},   {31'h0, m_mis});
            chk("epc_a",    if_a.epc,              m_epc);
            chk("pc_b",     if_b.pc,               m_pc);
            chk("flush_b",  {31'h0, if_b.pipe_flush}, {31'h0, exp_flush(3)});
            chk("mis_b",    {31'h0, if_b.misalign},   {31'h0, m_mis});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_br(input logic en, input logic [3:0] t, input logic [31:0] v, input logic [31:0] i);
        enable = en;
        branch = en;
        typ    = t;
        val1   = v;
        imm    = i;
    endtask

    // ---------------- directed stimulus with literal expectations ----------------
    initial begin
        repeat (2) tick();
        chk("rst_pc",    if_a.pc, 32'h0);
        chk("rst_hist",  if_a.pc_hist[63:32], 32'h0);
        chk("rst_flush", {31'h0, if_b.pipe_flush}, 32'h0);
        chk("rst_pc_w",  {16'h0, if_w.pc}, 32'h0000FFF0);
        rst_n = 1'b1;

        // Sequential run
        repeat (3) tick();
        chk("seq_pc_w3", {16'h0, if_w.pc}, 32'h0000FFFC);
        tick();
        chk("seq_pc",    if_a.pc, 32'h10);
        chk("seq_h0",    if_a.pc_hist[31:0], 32'h0C);
        chk("seq_h1",    if_a.pc_hist[63:32], 32'h08);
        chk("wrap_pc_w", {16'h0, if_w.pc}, 32'h0);
        chk("wrap_h0_w", {16'h0, if_w.pc_hist[15:0]}, 32'h0000FFFC);

        // Taken branch, PC-relative to previous PC
        set_br(1'b1, 4'h0, 32'h0, 32'h20);
        tick();
        set_br(1'b0, 4'h0, 32'h0, 32'h0);
        chk("br_pc",     if_a.pc, 32'h2C);
        chk("br_fl1_c1", {31'h0, if_a.pipe_flush}, 32'h1);
        chk("br_fl3_c1", {31'h0, if_b.pipe_flush}, 32'h1);
        tick();
        chk("br_fl1_c2", {31'h0, if_a.pipe_flush}, 32'h0);
        chk("br_fl3_c2", {31'h0, if_b.pipe_flush}, 32'h1);
        tick();
        chk("br_fl3_c3", {31'h0, if_b.pipe_flush}, 32'h1);
        tick();
        chk("br_fl3_c4", {31'h0, if_b.pipe_flush}, 32'h0);
        chk("br_pc_seq", if_a.pc, 32'h38);

        // jalr aligned, then jalr misaligned -> trap
        set_br(1'b1, T_JALR, 32'h101, 32'h0F);
        tick();
        chk("jalr_pc", if_a.pc, 32'h110);
        set_br(1'b1, T_JALR, 32'h102, 32'h0);
        tick();
        set_br(1'b0, 4'h0, 32'h0, 32'h0);
        chk("mis_pc",  if_a.pc, 32'h800);
        chk("mis_hi",  {31'h0, if_a.misalign}, 32'h1);
        chk("mis_epc", if_a.epc, 32'h38);
        tick();
        chk("mis_lo",  {31'h0, if_a.misalign}, 32'h0);
        chk("mis_epc_hold", if_a.epc, 32'h38);
        chk("mis_pc2", if_a.pc, 32'h804);

        // Stall beats branch, trap beats stall
        stall = 1'b1;
        set_br(1'b1, 4'h0, 32'h0, 32'h20);
        tick();
        chk("stall_pc",  if_a.pc, 32'h804);
        chk("stall_h0",  if_a.pc_hist[31:0], 32'h800);
        chk("stall_fl",  {31'h0, if_a.pipe_flush}, 32'h0);
        tick();
        chk("stall_fl3", {31'h0, if_b.pipe_flush}, 32'h0);
        trap     = 1'b1;
        trap_vec = 32'h900;
        tick();
        trap  = 1'b0;
        stall = 1'b0;
        set_br(1'b0, 4'h0, 32'h0, 32'h0);
        chk("trap_pc", if_a.pc, 32'h900);
        chk("trap_h0", if_a.pc_hist[31:0], 32'h804);
        chk("trap_fl", {31'h0, if_a.pipe_flush}, 32'h1);

        // Misaligned PC-relative branch
        set_br(1'b1, 4'h0, 32'h0, 32'h2);
        tick();
        set_br(1'b0, 4'h0, 32'h0, 32'h0);
        chk("mis2_pc",  if_a.pc, 32'h900);
        chk("mis2_epc", if_a.epc, 32'h804);
        tick();

        // Redirect during an active flush extends it
        set_br(1'b1, 4'h0, 32'h0, 32'h10);
        tick();
        chk("ext_pc1", if_a.pc, 32'h910);
        set_br(1'b0, 4'h0, 32'h0, 32'h0);
        tick();
        set_br(1'b1, 4'h0, 32'h0, 32'h0);
        tick();
        set_br(1'b0, 4'h0, 32'h0, 32'h0);
        chk("ext_pc2", if_a.pc, 32'h910);
        repeat (2) tick();
        chk("ext_fl3_on",  {31'h0, if_b.pipe_flush}, 32'h1);
        tick();
        chk("ext_fl3_off", {31'h0, if_b.pipe_flush}, 32'h0);

        // auipc via pc_out
        trap     = 1'b1;
        trap_vec = 32'h40;
        tick();
        trap = 1'b0;
        tick();
        stall = 1'b1;
        typ   = T_AUIPC;
        imm   = 32'h1000;
        #1;
        chk("auipc", if_a.pc_out, 32'h1040);
        typ = 4'h0;
        #1;
        chk("pcout_plain", if_a.pc_out, 32'h40);
        stall = 1'b0;
        imm   = 32'h0;

        // jalr with odd sum has bit 0 dropped
        set_br(1'b1, T_JALR, 32'h201, 32'h0);
        tick();
        set_br(1'b0, 4'h0, 32'h0, 32'h0);
        chk("jalr_odd", if_a.pc, 32'h200);

        // Asynchronous reset in the middle of a flush
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_pc",  if_a.pc, 32'h0);
        chk("arst_fl",  {31'h0, if_b.pipe_flush}, 32'h0);
        chk("arst_epc", if_a.epc, 32'h0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("post_rst_pc", if_a.pc, 32'h4);
        repeat (2) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
